// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
// The stall counter is only built when FIFO_ARB_STATS_EN is defined.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Requester slot reached by stepping `off` places past `base`, wrapping modulo n.
    function automatic int rr_slot(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write-port arbiter.
// The master modport is the arbiter; the slave modport is its surroundings.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          full;
    logic                          wr;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [CNT_W-1:0]              stall_cnt;

    modport master (
        input  req, req_data, full,
        output ack, grant, wr, w_data, stall_cnt
    );

    modport slave (
        output req, req_data, full,
        input  ack, grant, wr, w_data, stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    logic [IDX_W-1:0] slot_s;

    // Scan last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        slot_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            slot_s = IDX_W'(rr_slot(int'(last_i), k, NUM_REQ));
            if (!any_o && req_i[slot_s]) begin
                any_o          = 1'b1;
                idx_o          = slot_s;
                pick_o[slot_s] = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with bounded bursts.
// Optional stall statistics: define FIFO_ARB_STATS_EN to build the stall_cnt counter.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.master  bus
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic                busy_s, own_req_s, own_ack_s, release_s;
    logic [NUM_REQ-1:0]  pick_req_s, pick_s;
    logic [IDX_W-1:0]    pick_last_s, pick_idx_s;
    logic                pick_any_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    assign busy_s    = (state_q == ST_BUSY);
    assign own_req_s = busy_s & bus.req[owner_q];
    // Reset masks the accept so no word lands in the FIFO while the burst is being torn down.
    assign own_ack_s = own_req_s & ~bus.full & ~reset;
    assign release_s = busy_s & (~own_req_s | (own_ack_s & (beat_q == BEAT_LAST)));

    // One picker serves both the idle pick and the hand-over pick that excludes the outgoing owner.
    assign pick_req_s  = busy_s ? (bus.req & ~grant_q) : bus.req;
    assign pick_last_s = busy_s ? owner_q : last_q;

    fifo_wr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i  (pick_req_s),
        .last_i (pick_last_s),
        .pick_o (pick_s),
        .idx_o  (pick_idx_s),
        .any_o  (pick_any_s)
    );

    // State register for ownership, burst beat and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: grant from idle, hand over on release, count accepted beats.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d = ST_BUSY;
                    grant_d = pick_s;
                    owner_d = pick_idx_s;
                    beat_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (release_s) begin
                    last_d = owner_q;
                    if (pick_any_s) begin
                        grant_d = pick_s;
                        owner_d = pick_idx_s;
                        beat_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (own_ack_s) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Data mux follows the registered owner for as long as we are busy.
    always_comb begin
        wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wdata_s = wdata_s | ((busy_s && (owner_q == IDX_W'(i)))
                                 ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                 : {DATA_WIDTH{1'b0}});
        end
    end

    assign bus.grant  = grant_q;
    assign bus.ack    = own_ack_s ? grant_q : {NUM_REQ{1'b0}};
    assign bus.wr     = own_ack_s;
    assign bus.w_data = wdata_s;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles the owner had a word but the FIFO was full.
    always_comb begin
        if (own_req_s && bus.full && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a randomized scoreboard run.
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int CW    = 16;
    localparam int WORDS = 20;
    localparam int NPROD = 3;
    localparam int LIMIT = 4000;
`ifdef FIFO_ARB_STATS_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] eg;
        logic [3:0] ea;
        logic       ew;
    } vec_t;
    vec_t vecs[$];

    // reference model state (owner -1 means idle)
    int m_owner, m_last, m_taken;
    int nxt[NPROD];
    int exp_nxt[NPROD];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic f);
        @(negedge clk);
        reset    = r;
        bus.req  = q;
        bus.full = f;
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic f,
                       input logic [3:0] eg, input logic [3:0] ea, input logic ew);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.eg = eg; v.ea = ea; v.ew = ew;
        vecs.push_back(v);
    endtask

    function automatic int rr_first(input logic [3:0] rq, input int last, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (c != excl && rq[c[1:0]]) return c;
        end
        return -1;
    endfunction

    function automatic bit all_done();
        for (int p = 0; p < NPROD; p++) begin
            if (exp_nxt[p] < WORDS) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        logic [3:0]  rq, m_ack, ack_prev, req_r, m_grant;
        logic [31:0] rd;
        logic        fl;
        int          cyc, id, seq;
        bit          done;

        bus.req      = '0;
        bus.full     = 1'b0;
        bus.req_data = 32'h4433_2211;
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);

        // single requester, 3 words
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // all four requesting: bursts of MB in order 0,1,2,3,0
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int o = 0; o < 4; o++) begin
            for (int b = 0; b < MB; b++) begin
                add(1'b0, 4'b1111, 1'b0, 4'(4'b0001 << o), 4'(4'b0001 << o), 1'b1);
            end
        end
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // wrap-around: last owner 3, then 1001 -> 0 then 3 with no bubble
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0);
        add(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b0001, 4'b0000, 1'b0);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // grant while full, first ack when full drops
        add(1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].full);
            chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_wr", i), 32'(bus.wr), 32'(vecs[i].ew));
            if (vecs[i].ew) chk($sformatf("vec%0d_wdata", i), 32'(bus.w_data), 32'(8'h11 * (8'(vecs[i].ea) == 8'd1 ? 8'd1 : vecs[i].ea == 4'b0010 ? 8'd2 : vecs[i].ea == 4'b0100 ? 8'd3 : 8'd4)));
            @(posedge clk);
        end

        // full stall mid-burst of owner 2
        drive(1'b1, 4'b0000, 1'b0); @(posedge clk);
        drive(1'b0, 4'b0100, 1'b0); @(posedge clk);
        drive(1'b0, 4'b0100, 1'b0); chk("stall_ack_b0", 32'(bus.ack), 32'h4); @(posedge clk);
        drive(1'b0, 4'b0100, 1'b0); chk("stall_ack_b1", 32'(bus.ack), 32'h4); @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b0100, 1'b1);
            chk("stall_ack", 32'(bus.ack), 32'h0);
            chk("stall_wr", 32'(bus.wr), 32'h0);
            chk("stall_grant", 32'(bus.grant), 32'h4);
            @(posedge clk);
        end
        drive(1'b0, 4'b0100, 1'b0); chk("resume_b2", 32'(bus.ack), 32'h4); @(posedge clk);
        drive(1'b0, 4'b0100, 1'b0); chk("resume_b3", 32'(bus.ack), 32'h4); @(posedge clk);
        drive(1'b0, 4'b0100, 1'b0);
        chk("burst_end_grant", 32'(bus.grant), 32'h0);
        chk("burst_end_wr", 32'(bus.wr), 32'h0);
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(EXP_STALL));
        @(posedge clk);
        drive(1'b0, 4'b0000, 1'b0); chk("regrant_via_idle", 32'(bus.grant), 32'h4); @(posedge clk);

        // reset at beat 2 of owner 1
        drive(1'b1, 4'b0000, 1'b0); @(posedge clk);
        drive(1'b0, 4'b0010, 1'b0); @(posedge clk);
        drive(1'b0, 4'b0010, 1'b0); chk("rst_b0", 32'(bus.ack), 32'h2); @(posedge clk);
        drive(1'b0, 4'b0010, 1'b0); chk("rst_b1", 32'(bus.ack), 32'h2); @(posedge clk);
        drive(1'b1, 4'b0010, 1'b0); chk("rst_cycle_wr", 32'(bus.wr), 32'h0); @(posedge clk);
        drive(1'b0, 4'b0011, 1'b0);
        chk("rst_after_grant", 32'(bus.grant), 32'h0);
        chk("rst_after_wr", 32'(bus.wr), 32'h0);
        chk("rst_after_stall", 32'(bus.stall_cnt), 32'h0);
        @(posedge clk);
        drive(1'b0, 4'b0000, 1'b0); chk("rst_first_pick", 32'(bus.grant), 32'h1); @(posedge clk);

        // randomized producers against the reference model and scoreboard
        drive(1'b1, 4'b0000, 1'b0); @(posedge clk);
        m_owner = -1; m_last = N - 1; m_taken = 0;
        for (int p = 0; p < NPROD; p++) begin nxt[p] = 0; exp_nxt[p] = 0; end
        req_r = '0; ack_prev = '0; cyc = 0;
        while (!all_done() && cyc < LIMIT) begin
            @(negedge clk);
            reset = 1'b0;
            for (int p = 0; p < NPROD; p++) begin
                if (ack_prev[p]) nxt[p]++;
                if (!(req_r[p] && !ack_prev[p]))
                    req_r[p] = (nxt[p] < WORDS) && ($urandom_range(0, 2) != 0);
            end
            req_r[3] = 1'b0;
            rd = '0;
            for (int p = 0; p < NPROD; p++) rd[p*8 +: 8] = 8'(p * 32 + nxt[p]);
            fl = ($urandom_range(0, 3) == 0);
            bus.req = req_r; bus.req_data = rd; bus.full = fl;
            #1;
            rq = req_r;
            m_grant = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
            m_ack = (m_owner >= 0 && rq[m_owner[1:0]] && !fl) ? m_grant : 4'b0000;
            chk("rand_grant", 32'(bus.grant), 32'(m_grant));
            chk("rand_ack", 32'(bus.ack), 32'(m_ack));
            chk("rand_wr", 32'(bus.wr), 32'(|m_ack));
            if (fl) chk("rand_no_wr_full", 32'(bus.wr), 32'h0);
            if (m_ack != 0) chk("rand_wdata", 32'(bus.w_data), 32'(8'(m_owner * 32 + nxt[m_owner])));
            if (bus.wr === 1'b1) begin
                id  = int'(bus.w_data[7:5]);
                seq = int'(bus.w_data[4:0]);
                chk("sb_id_valid", 32'(id < NPROD), 32'h1);
                if (id < NPROD) begin
                    chk("sb_order", 32'(seq), 32'(exp_nxt[id]));
                    exp_nxt[id]++;
                end
            end
            ack_prev = bus.ack;
            @(posedge clk);
            if (m_owner < 0) begin
                m_owner = rr_first(rq, m_last, -1);
                m_taken = 0;
            end else begin
                done = !rq[m_owner[1:0]] || (m_ack != 0 && m_taken + 1 == MB);
                if (m_ack != 0) m_taken++;
                if (done) begin
                    m_last  = m_owner;
                    m_owner = rr_first(rq, m_last, m_last);
                    m_taken = 0;
                end
            end
            cyc++;
        end
        chk("rand_within_budget", 32'(cyc < LIMIT), 32'h1);
        for (int p = 0; p < NPROD; p++) chk($sformatf("sb_count%0d", p), 32'(exp_nxt[p]), 32'(WORDS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
